countdown_timer_8bit: RTL and testbench

Loadable 8-bit down-counting timer that is the complement of the 8-bit up-counter. It decrements from a programmed value on each enable tick and flags expiry with a one-cycle `done` pulse. It supports one-shot and auto-reload (periodic) modes. Peripheral logic uses it for timeouts and periodic events next to the free-running counter.

---
 rtl/countdown_timer_8bit_pkg.sv | 7 +
 rtl/countdown_timer_8bit_adder.sv | 10 +
 rtl/countdown_timer_8bit.sv | 54 +++++
 tb/tb_countdown_timer_8bit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/countdown_timer_8bit_pkg.sv
// countdown_timer_8bit_pkg: shared width, state encoding and state type for the countdown timer
package countdown_timer_8bit_pkg;
  localparam logic TIMER_IDLE = 1'b0;
  localparam logic TIMER_RUN = 1'b1;
  localparam int TIMER_WIDTH = 8;
  typedef enum logic {IDLE = TIMER_IDLE, RUN = TIMER_RUN} timer_state_t;
endpackage

// File: rtl/countdown_timer_8bit_adder.sv
// adder_8bit: 8-bit ripple adder with carry in/out
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

// File: rtl/countdown_timer_8bit.sv
// countdown_timer_8bit: loadable down-counter with one-shot/auto-reload expiry pulse
module countdown_timer_8bit
  import countdown_timer_8bit_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_value,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   auto_reload,
  input  logic                   enable,
  output logic [TIMER_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done
);
  timer_state_t state;
  logic [TIMER_WIDTH-1:0] reload;
  logic [TIMER_WIDTH-1:0] dec;
  logic cout_unused;
  // adding 0xFF modulo 256 is count - 1
  adder_8bit u_dec (
    .a(count),
    .b(8'hFF),
    .cin(1'b0),
    .sum(dec),
    .cout(cout_unused)
  );
  assign busy = (state == RUN);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      reload <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count <= load_value;
        reload <= load_value;
        state <= IDLE;
      end else if (state == RUN) begin
        if (stop) state <= IDLE;
        else if (enable) begin
          if (count == 8'd1) begin
            done <= 1'b1;
            count <= auto_reload ? reload : dec;
            state <= auto_reload ? RUN : IDLE;
          end else count <= dec;
        end
      end else if (start && count != '0) state <= RUN;
    end
  end
endmodule

// File: tb/tb_countdown_timer_8bit.sv
// tb_countdown_timer_8bit: directed and randomized checks against a behavioural timer model
module tb_countdown_timer_8bit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0, start = 1'b0, stop = 1'b0, auto_reload = 1'b0, enable = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic [7:0] count;
  logic busy, done;
  int total = 0, passed = 0;
  int m_count = 0, m_reload = 0;
  bit m_run = 0, m_done = 0;

  countdown_timer_8bit dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .start(start),
    .stop(stop), .auto_reload(auto_reload), .enable(enable), .count(count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // behavioural model: remaining ticks, running flag, expiry pulse
  always @(posedge clk or posedge reset) begin
    int c, r;
    bit run, d;
    if (reset) begin
      m_count <= 0; m_reload <= 0; m_run <= 0; m_done <= 0;
    end else begin
      c = m_count; r = m_reload; run = m_run; d = 0;
      if (load) begin c = load_value; r = load_value; run = 0; end
      else if (run && stop) run = 0;
      else if (!run && start) run = (c != 0);
      else if (run && enable) begin
        c = c - 1;
        if (c == 0) begin
          d = 1;
          if (auto_reload) c = r; else run = 0;
        end
      end
      m_count <= c; m_reload <= r; m_run <= run; m_done <= d;
    end
  end

  always @(negedge clk) if (!reset) begin
    check("model_count", count, m_count);
    check("model_busy", busy, m_run);
    check("model_done", done, m_done);
  end

  task automatic drive(input bit l, input int lv, input bit st, input bit sp, input bit ar, input bit en);
    load = l; load_value = lv[7:0]; start = st; stop = sp; auto_reload = ar; enable = en;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_count", count, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    // one-shot from 5
    drive(1, 5, 0, 0, 0, 0);
    check("os_load", count, 5);
    drive(0, 0, 1, 0, 0, 1);
    check("os_start_count", count, 5);
    check("os_start_busy", busy, 1);
    for (int k = 4; k >= 1; k--) begin
      drive(0, 0, 0, 0, 0, 1);
      check("os_count", count, k);
      check("os_done_low", done, 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    check("os_exp_count", count, 0);
    check("os_exp_done", done, 1);
    check("os_exp_busy", busy, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("os_done_once", done, 0);
    // auto-reload from 3
    drive(1, 3, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 1);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 0, 1, 1);
      check("ar_count", count, (k % 3 == 0) ? 3 : 3 - (k % 3));
      check("ar_done", done, (k % 3 == 0) ? 1 : 0);
      check("ar_busy", busy, 1);
    end
    // gated ticks then stop, then resume
    drive(1, 4, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("gt_c3", count, 3);
    drive(0, 0, 0, 0, 0, 0);
    check("gt_hold", count, 3);
    drive(0, 0, 0, 0, 0, 1);
    check("gt_c2", count, 2);
    drive(0, 0, 0, 1, 0, 1);
    check("stop_count", count, 2);
    check("stop_busy", busy, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("resume_busy", busy, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("resume_c1", count, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("resume_done", done, 1);
    check("resume_count", count, 0);
    // load beats stop and enable at count 1
    drive(1, 2, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("pri_pre", count, 1);
    drive(1, 8'h10, 0, 1, 0, 1);
    check("pri_count", count, 8'h10);
    check("pri_busy", busy, 0);
    check("pri_done", done, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1);
    check("zero_start_busy", busy, 0);
    check("zero_start_done", done, 0);
    // full-width run from 0xFF
    drive(1, 8'hFF, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1);
    for (int k = 1; k <= 255; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      check("wrap_count", count, 255 - k);
      check("wrap_done", done, k == 255);
    end
    // asynchronous reset mid-run at 0x37
    drive(1, 8'h37, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    // randomized traffic, checked every cycle against the model
    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 15) == 0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6),
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
